mem_arbiter: RTL
================

# mem_arbiter

Two-requester round-robin arbiter and access sequencer for the shared 32x8 single-port memory (`read`/`write`/`addr`/`data_in`/`data_out`). It sits between two masters (e.g. a test driver and a DMA/scrub engine) and the memory interface.
- Drives exactly one memory command at a time.
- Returns read data to the requester that issued it.
- Guarantees `mem_read` and `mem_write` are never high together.

## Interface
- ADDR_W, 5, memory address width (32 locations)
- DATA_W, 8, memory data width
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req0, req1  in  1  access request from requester 0/1
- we0, we1  in  1  1 = write, 0 = read; qualified by reqN
- addr0, addr1  in  ADDR_W  request address
- wdata0, wdata1  in  DATA_W  write data (ignored for reads)
- gnt0, gnt1  out  1  one-cycle pulse: request accepted and issued to memory this cycle
- rvalid0, rvalid1  out  1  one-cycle pulse: rdata holds read result for that requester
- rdata  out  DATA_W  registered read data, shared by both requesters
- busy  out  1  high whenever state != IDLE
- mem_read, mem_write  out  1  memory command strobes (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_data_in  out  DATA_W  memory write data (registered)
- mem_data_out  in  DATA_W  memory read data; valid the cycle after the cycle mem_read is high

## Operation
- FSM states: IDLE, ACCESS, RDATA.
- **IDLE:** sample req0/req1 at the rising edge.
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the requester that is not `last`.
  - On a grant: latch the winner index, we, addr and wdata into the mem_* registers, go to ACCESS.
- **ACCESS (1 cycle):**
  - mem_write = we and mem_read = !we for the winner; gntN = 1 for the winner only.
  - `last` updates to the winner.
  - Next state: RDATA if the access is a read, else IDLE.
- **RDATA (1 cycle):**
  - All mem_* strobes low.
  - rdata captured from mem_data_out at the edge ending RDATA.
  - rvalidN for the winner set for the following cycle; that cycle is IDLE.
- **Requester rules:**
  - Hold reqN, weN, addrN, wdataN stable from assertion until gntN is seen.
  - Deassert or change them at the edge ending the gnt cycle.
  - Dropping req before gnt is legal and withdraws the request.
- mem_addr and mem_data_in hold their last values outside ACCESS. mem_data_in is don't-care for reads.
- rdata holds its value until the next read completes.

## Timing
- **Reset:** at an edge with rst = 1, all registered outputs go to 0 the next cycle:
  - gnt0/1, rvalid0/1, rdata, mem_read, mem_write, mem_addr, mem_data_in.
  - State goes to IDLE.
  - `last` = 1, so requester 0 wins the first contended arbitration.
- **Reset mid-operation** (ACCESS or RDATA): the access is aborted, with no gnt or rvalid afterwards. A write already strobed in ACCESS is not undone.
- **Write latency:** req sampled at edge E0; ACCESS and gnt during E0–E1; memory writes at E1; IDLE during E1–E2. Back-to-back writes from one requester take 2 cycles each.
- **Read latency:** req sampled at E0; ACCESS/gnt during E0–E1; RDATA during E1–E2; rvalid and rdata during E2–E3. A read occupies 3 cycles, and a new request can be sampled at E3.
- **Contention:** requests from both sides alternate strictly, 0, 1, 0, 1, ..., regardless of we. A requester never waits more than one access of the other requester.
- gnt0 & gnt1, rvalid0 & rvalid1, and mem_read & mem_write are each mutually exclusive in every cycle.
- busy is combinational from state.

## Test plan
- **Reset values:** assert rst for 2 cycles with req0=req1=1.
  - All outputs read 0 during and 1 cycle after reset.
  - The first grant after reset is gnt0.
- **Single write then read:**
  - req0, we0=1, addr0=5'h03, wdata0=8'hA5: gnt0 one cycle with mem_write=1, mem_addr=03, mem_data_in=A5.
  - Then req0, we0=0, addr0=03: gnt0 with mem_read=1; two cycles after gnt, rvalid0=1 and rdata=A5; rvalid1 stays 0.
- **Round-robin under contention:** req0 and req1 held continuously, alternating writes to addr = 0..31 with data = addr.
  - Grants alternate 0,1,0,1, never both high.
  - A full readback returns data = addr at all 32 locations.
- **Mixed contention:** req0 read of addr 31 and req1 write of 8'h5A to addr 0 asserted on the same edge.
  - gnt0 first with mem_read; RDATA; rvalid0 with the stale value at 31; then gnt1 with mem_write.
  - mem_read and mem_write never overlap.
- **Reset mid-read:** assert rst during RDATA.
  - No rvalid is produced, rdata = 0, and state returns to IDLE.
  - A subsequent req1 read is granted normally.
- **Request withdrawal:**
  - req1 asserted then dropped while an access for requester 0 is in ACCESS: no gnt1 is ever produced.
  - The next arbitration with only req0 grants requester 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester round-robin arbiter and access sequencer for a shared
// single-port memory. One memory command is issued at a time, read data is
// routed back to the requester that issued the read, and the read/write
// strobes are never asserted together.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   req0/1, we0/1       : request and direction (1 = write) per requester
//   addr0/1, wdata0/1   : request address and write data per requester
//   gnt0/1              : one-cycle pulse, request issued to memory this cycle
//   rvalid0/1           : one-cycle pulse, rdata holds that requester's result
//   rdata               : registered read data, shared by both requesters
//   busy                : high whenever the sequencer is not idle
//   mem_read, mem_write : registered memory command strobes
//   mem_addr            : registered memory address
//   mem_data_in         : registered memory write data
//   mem_data_out        : memory read data, valid the cycle after mem_read
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;      // requester served most recently
  logic              win_q, win_d;        // requester owning the current access
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;

  logic              grant_any;
  logic              grant_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Arbitration: on contention the requester that was not served last wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (req0 && req1) begin
      grant_any = 1'b1;
      grant_idx = ~last_q;
    end else if (req0) begin
      grant_any = 1'b1;
      grant_idx = 1'b0;
    end else if (req1) begin
      grant_any = 1'b1;
      grant_idx = 1'b1;
    end else begin
      grant_any = 1'b0;
      grant_idx = 1'b0;
    end
  end

  // Request mux: select the winning requester's command fields.
  always_comb begin
    if (grant_idx) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end else begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_q        <= 1'b1;  // requester 0 wins the first contended round
      win_q         <= 1'b0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata_q       <= {DATA_W{1'b0}};
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_data_in_q <= {DATA_W{1'b0}};
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      win_q         <= win_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      rdata_q       <= rdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  // Next-state logic; mem_read_q marks the access in flight as a read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mem_read_q) begin
          state_d = ST_RDATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RDATA: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: strobes and pulses default low, datapath registers hold.
  always_comb begin
    last_d        = last_q;
    win_d         = win_q;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
    rdata_d       = rdata_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    case (state_q)
      ST_IDLE: begin
        // Loading at the arbitration edge makes gnt and the strobes visible
        // during the ACCESS cycle itself.
        if (grant_any) begin
          win_d       = grant_idx;
          gnt0_d      = ~grant_idx;
          gnt1_d      = grant_idx;
          mem_write_d = sel_we;
          mem_read_d  = ~sel_we;
          mem_addr_d  = sel_addr;
          if (sel_we) begin
            mem_data_in_d = sel_wdata;
          end else begin
            mem_data_in_d = mem_data_in_q;
          end
        end else begin
          win_d = win_q;
        end
      end
      ST_ACCESS: begin
        last_d = win_q;
      end
      ST_RDATA: begin
        // Memory data is valid now; capture it and flag the owner next cycle.
        rdata_d   = mem_data_out;
        rvalid0_d = ~win_q;
        rvalid1_d = win_q;
      end
      default: begin
        last_d = last_q;
      end
    endcase
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata       = rdata_q;
  assign busy        = (state_q != ST_IDLE);
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;

endmodule
